// File: rtl/k8088_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// k8088_bus_pkg: shared types for the k8088 memory bus controller.  Rev 1.0
// ---------------------------------------------------------------------------
package k8088_bus_pkg;

  localparam int CNT_W = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/k8088_membus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// k8088_membus: byte-wide async SRAM controller pacing the k8088 core through
// cpu_chipen, time-shared with a read-only video fetch port.  Rev 1.0
// ---------------------------------------------------------------------------
module k8088_membus
  import k8088_bus_pkg::*;
#(
  parameter int unsigned WAIT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_chipen,
  input  logic        vid_req,
  input  logic [19:0] vid_address,
  output logic [7:0]  vid_data,
  output logic        vid_ack,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic        mem_oe
);

  localparam cnt_t WAIT_C = cnt_t'(WAIT);

  state_e      state_q;
  owner_e      owner_q;
  cnt_t        cnt_q;
  logic        last_vid_q;
  logic [19:0] mem_address_q;
  logic [7:0]  mem_wdata_q;
  logic [7:0]  cpu_in_q;
  logic [7:0]  vid_data_q;
  logic        cpu_chipen_q;
  logic        vid_ack_q;
  logic        mem_we_q;
  logic        mem_oe_q;

  // Video may take a slot only if the previous grant went to the CPU.
  logic last_vid_d;
  logic wr_d;

  assign last_vid_d = vid_req & ~last_vid_q;
  assign wr_d       = ~last_vid_d & cpu_we;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_CPU;
      cnt_q         <= '0;
      last_vid_q    <= 1'b0;
      mem_address_q <= 20'h00000;
      mem_wdata_q   <= 8'h00;
      cpu_in_q      <= 8'h00;
      vid_data_q    <= 8'h00;
      cpu_chipen_q  <= 1'b0;
      vid_ack_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
    end else begin
      cpu_chipen_q <= 1'b0;
      vid_ack_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          owner_q       <= last_vid_d ? OWN_VID : OWN_CPU;
          last_vid_q    <= last_vid_d;
          mem_address_q <= last_vid_d ? vid_address : cpu_address;
          mem_wdata_q   <= cpu_out;
          mem_we_q      <= wr_d;
          mem_oe_q      <= ~wr_d;
          cnt_q         <= WAIT_C;
          state_q       <= ST_ACC;
        end
        ST_ACC: begin
          if (cnt_q == '0) begin
            mem_we_q <= 1'b0;
            mem_oe_q <= 1'b0;
            if (mem_oe_q) begin
              if (owner_q == OWN_VID) vid_data_q <= mem_rdata;
              else                    cpu_in_q   <= mem_rdata;
            end
            if (owner_q == OWN_VID) vid_ack_q    <= 1'b1;
            else                    cpu_chipen_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_in      = cpu_in_q;
  assign cpu_chipen  = cpu_chipen_q;
  assign vid_data    = vid_data_q;
  assign vid_ack     = vid_ack_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_oe      = mem_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_k8088_membus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_k8088_membus: four controller lanes (WAIT=0,1,3,7) under random core and
// video traffic, scored against a slot-timing and memory reference model.
// ---------------------------------------------------------------------------
module tb_k8088_membus;

  localparam int NLANE  = 4;
  localparam int CYCLES = 3000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #20 clock = ~clock;

  task automatic chk(input string nm, input int lane, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", nm, lane, act, exp, $time);
    end
  endtask

  // Power-up SRAM contents: any address not yet written reads this pattern.
  function automatic logic [7:0] dflt(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
  endfunction

  typedef struct packed {
    logic        vid;
    logic [19:0] addr;
    logic        we;
    logic [7:0]  data;
  } acc_t;

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    localparam int W = (gi == 0) ? 0 : (gi == 1) ? 1 : (gi == 2) ? 3 : 7;

    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        cpu_chipen;
    logic        vid_req;
    logic [19:0] vid_address;
    logic [7:0]  vid_data;
    logic        vid_ack;
    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_we;
    logic        mem_oe;

    logic [7:0] sram [logic [19:0]];
    logic [7:0] refm [logic [19:0]];
    acc_t       q[$];
    acc_t       grant_a;
    acc_t       cur;
    int         phase = 0;
    logic       last_vid = 1'b0;
    logic [7:0] exp_cpu_in = 8'h00;
    logic [7:0] exp_vid_data = 8'h00;
    int         issued = 0;
    logic       s_exp;
    logic       done_exp;

    k8088_membus #(.WAIT(W)) u_dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cpu_address (cpu_address),
      .cpu_out     (cpu_out),
      .cpu_we      (cpu_we),
      .cpu_in      (cpu_in),
      .cpu_chipen  (cpu_chipen),
      .vid_req     (vid_req),
      .vid_address (vid_address),
      .vid_data    (vid_data),
      .vid_ack     (vid_ack),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_we      (mem_we),
      .mem_oe      (mem_oe)
    );

    function automatic logic [7:0] rd_ref(input logic [19:0] a);
      return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    // Core model: first a read of 0xFFFF0, then a write of 0x5A to 0x00400,
    // then random traffic. CPU writes stay below 0x80000; video reads above.
    task automatic next_cpu();
      logic [19:0] pool;
      int unsigned sel;
      issued++;
      pool = (($urandom_range(0, 1) == 0) ? 20'h00000 : 20'h00400) | 20'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      cpu_out = 8'($urandom);
      if (issued == 1) begin
        cpu_address = 20'hFFFF0;
        cpu_we      = 1'b0;
      end else if (issued == 2) begin
        cpu_address = 20'h00400;
        cpu_we      = 1'b1;
        cpu_out     = 8'h5A;
      end else begin
        cpu_we = (sel < 4);
        if (sel < 7)       cpu_address = pool;
        else if (sel == 7) cpu_address = 20'hFFFFF;
        else if (sel == 8) cpu_address = 20'hFFFF0;
        else               cpu_address = {1'b1, 19'($urandom)};
      end
    endtask

    initial begin
      sram[20'hFFFF0] = 8'hEA;
      refm[20'hFFFF0] = 8'hEA;
      vid_req     = 1'b0;
      vid_address = 20'h80000;
      next_cpu();
    end

    // The core advances exactly once per chipen pulse.
    always @(negedge clock) begin
      if (cpu_chipen) next_cpu();
    end

    // Video requester: address held until acknowledged; request occasionally
    // withdrawn and reasserted to exercise both sides of the grant edge.
    always @(negedge clock) begin
      if (vid_ack) begin
        vid_address = ($urandom_range(0, 7) == 0) ? 20'hFFFF0
                                                  : {1'b1, 13'h0, 6'($urandom_range(0, 63))};
        vid_req = ($urandom_range(0, 3) != 0);
      end else if (issued >= 3 && $urandom_range(0, 15) == 0) begin
        vid_req = ~vid_req;
      end
    end

    // Asynchronous SRAM.
    always @(negedge clock) begin
      if (mem_we) sram[mem_address] = mem_wdata;
      mem_rdata = mem_oe ? (sram.exists(mem_address) ? sram[mem_address] : dflt(mem_address))
                         : 8'h00;
    end

    // Reference: the bus is a continuous train of slots of WAIT+3 cycles; the
    // first cycle of each slot decides the owner and captures the request.
    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        phase    = 0;
        last_vid = 1'b0;
        q.delete();
      end else begin
        if (phase == 0) begin
          grant_a.vid  = vid_req && !last_vid;
          last_vid     = grant_a.vid;
          grant_a.addr = grant_a.vid ? vid_address : cpu_address;
          grant_a.we   = grant_a.vid ? 1'b0 : cpu_we;
          grant_a.data = cpu_out;
          q.push_back(grant_a);
        end
        phase = (phase == W + 2) ? 0 : phase + 1;
      end
    end

    // Monitor: compare the bus against the head of the scoreboard each cycle.
    always @(negedge clock) begin
      if (!reset_n) begin
        exp_cpu_in   = 8'h00;
        exp_vid_data = 8'h00;
      end else begin
        s_exp    = (phase >= 1) && (phase <= W + 1);
        done_exp = (phase == W + 2);
        cur      = (q.size() != 0) ? q[0] : '0;
        if (s_exp || done_exp) chk("scoreboard_entry", gi, 32'(q.size()), 32'd1);
        chk("mem_oe", gi, 32'(mem_oe), 32'(s_exp && !cur.we));
        chk("mem_we", gi, 32'(mem_we), 32'(s_exp && cur.we));
        if (s_exp) begin
          chk("mem_address", gi, 32'(mem_address), 32'(cur.addr));
          if (cur.we) chk("mem_wdata", gi, 32'(mem_wdata), 32'(cur.data));
        end
        chk("cpu_chipen", gi, 32'(cpu_chipen), 32'(done_exp && !cur.vid));
        chk("vid_ack", gi, 32'(vid_ack), 32'(done_exp && cur.vid));
        if (done_exp && q.size() != 0) begin
          if (cur.vid)     exp_vid_data = rd_ref(cur.addr);
          else if (cur.we) refm[cur.addr] = cur.data;
          else             exp_cpu_in = rd_ref(cur.addr);
          void'(q.pop_front());
        end
        chk("cpu_in", gi, 32'(cpu_in), 32'(exp_cpu_in));
        chk("vid_data", gi, 32'(vid_data), 32'(exp_vid_data));
      end
    end

    // Reset must clear every output without waiting for a clock edge.
    always @(negedge reset_n) begin
      #1;
      chk("reset_mem_address", gi, 32'(mem_address), 32'd0);
      chk("reset_data", gi, 32'({cpu_in, vid_data, mem_wdata}), 32'd0);
      chk("reset_ctl", gi, 32'({cpu_chipen, vid_ack, mem_we, mem_oe}), 32'd0);
    end
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (1200) @(negedge clock);
    begin : mid_reset
      automatic int k = 0;
      while (g_lane[2].mem_we !== 1'b1 && k < 2000) begin
        @(negedge clock);
        k++;
      end
      chk("mid_write_found", 2, 32'(k < 2000), 32'd1);
      if (k < 2000) begin
        #5 reset_n = 1'b0;
        #1 chk("async_we_drop", 2, 32'(g_lane[2].mem_we), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
      end
    end
    repeat (CYCLES) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k8088_membus.md
Name: k8088_membus

Overview:
- Memory bus controller directly downstream of the k8088 core.
- Takes the core's single byte-wide access (address/out/we) and performs it on external asynchronous SRAM with a configurable number of wait states.
- Time-shares the SRAM with a read-only video fetch port.
- Paces the core through its `chipen` input, so the core advances exactly once per completed access.

Parameters:
- WAIT, 1, extra SRAM cycles per access (0..7); an access holds the SRAM strobes for WAIT+1 cycles.

Ports:
- clock  in  1  system clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- cpu_address  in  20  core address for the current access
- cpu_out  in  8  core write data
- cpu_we  in  1  core write strobe (1 = write)
- cpu_in  out  8  read data to the core; holds its value between accesses
- cpu_chipen  out  1  single-cycle advance pulse to the core
- vid_req  in  1  video read request, level, held until vid_ack
- vid_address  in  20  video read address
- vid_data  out  8  video read data, valid while vid_ack=1 and held afterwards
- vid_ack  out  1  single-cycle completion pulse for video
- mem_address  out  20  SRAM address, registered
- mem_wdata  out  8  SRAM write data, registered
- mem_rdata  in  8  SRAM read data
- mem_we  out  1  SRAM write enable, active high
- mem_oe  out  1  SRAM output enable, active high

Behaviour:
- Clock and reset: one clock domain. reset_n=0 asynchronously clears all state.
  - State goes to IDLE; the wait counter and fairness bit go to 0.
  - cpu_in, vid_data and mem_wdata go to 0x00; mem_address goes to 0x00000.
  - cpu_chipen, vid_ack, mem_we and mem_oe go to 0.
- States: IDLE, ACC, DONE.
- IDLE:
  - The core always has a pending access.
  - Grant goes to video if vid_req=1 and the previous grant was to the CPU (fairness bit last_vid=0); otherwise the grant goes to the CPU.
  - At the grant edge the controller registers:
    - mem_address from the winner's address;
    - mem_wdata from cpu_out;
    - the write flag (cpu_we for a CPU grant, 0 for video);
    - the owner, last_vid, and counter = WAIT.
  - Next state is ACC.
- ACC:
  - mem_oe=1 for reads; mem_we=1 for writes. Exactly one of the two is active, and both are decoded from registered state.
  - The counter decrements each cycle.
  - On the edge where counter=0:
    - a read latches mem_rdata into cpu_in or vid_data, according to the owner;
    - next state is DONE.
  - ACC therefore lasts exactly WAIT+1 cycles.
- DONE:
  - Both strobes are 0.
  - cpu_chipen=1 (CPU owner) or vid_ack=1 (video owner) for exactly this one cycle.
  - Next state is IDLE. IDLE re-samples cpu_address because the core updates it at the DONE edge.
- Latency, uncontended: IDLE is cycle 0, ACC is cycles 1..WAIT+1, DONE is cycle WAIT+2. One access takes WAIT+3 cycles.
- Fairness: video never gets two consecutive grants. The CPU is guaranteed at least every other slot.
- cpu_chipen and vid_ack are never high in the same cycle. cpu_chipen is 0 in every non-DONE cycle.
- Write data: cpu_in is not modified by a write. mem_wdata and mem_address are stable for the whole ACC period.
- Video request withdrawn:
  - If vid_req drops after the grant, the access still completes and vid_ack is still pulsed.
  - If vid_req drops before the grant, video is not granted.
- Reset mid-access: strobes drop immediately (asynchronously), no completion pulse is issued, and the state is IDLE after release.
- Address arithmetic: 20-bit pass-through with no wrap handling. The core delivers linear addresses.

Decomposition:
- Package k8088_bus_pkg: state encoding (IDLE/ACC/DONE), owner encoding (OWN_CPU/OWN_VID), 3-bit wait-counter width.
- No sub-module. The arbiter and the counter are a few lines each inside the FSM.

Test Plan:
- CPU read, WAIT=1, vid_req=0, SRAM[0xFFFF0]=0xEA:
  - mem_oe=1 in cycles 1-2, cpu_chipen=1 only in cycle 3, cpu_in=0xEA from cycle 3 on;
  - period 4 cycles per access.
- CPU write, WAIT=0, cpu_address=0x00400, cpu_out=0x5A, cpu_we=1:
  - mem_we=1 for exactly 1 cycle with mem_address=0x00400 and mem_wdata=0x5A;
  - cpu_in is unchanged; cpu_chipen pulses in cycle 2.
- vid_req held at 1 continuously, WAIT=1:
  - grants alternate VID, CPU, VID, CPU;
  - vid_ack and cpu_chipen each pulse once per 8 cycles and never coincide;
  - vid_data follows SRAM[vid_address].
- vid_req drops 1 cycle after the grant: vid_ack still pulses once, with vid_data latched from the SRAM.
- reset_n pulled low in the middle of a WAIT=3 write: mem_we falls in the same cycle with no clock edge needed; after release the state is IDLE, all outputs are 0, and the next access completes normally.
- WAIT=7, back-to-back CPU reads: cpu_chipen period is exactly 10 cycles and mem_oe is high for 8 cycles each access.
